// File: rtl/dac_sample_sequencer.sv
// dac_sample_sequencer
//   Streams 10-bit samples from the register interface to the parallel DAC
//   pins at a programmable sample rate. It also handles DAC power sequencing
//   (power-down, wake delay, run, orderly stop). Samples are buffered in an
//   internal FIFO of depth 2**FIFO_AW.
//
// Ports
//   Bus2IP_Clk, Bus2IP_Reset : clock, synchronous active-high reset
//   ctrl_enable              : 1 = power up and stream, 0 = stop and power down
//   clk_div                  : sample period = 2*(clk_div+1) clocks
//   fmt_twos                 : sample format flag, forwarded to dac_format
//   wr_valid/wr_data/wr_ready: sample write handshake into the FIFO
//   fifo_level               : FIFO occupancy, 0..2**FIFO_AW
//   underflow/underflow_clr  : sticky "period began with empty FIFO" flag
//   busy                     : sequencer is not in OFF
//   dac_*                    : DAC pin drives
module dac_sample_sequencer #(
    parameter int FIFO_AW     = 4,
    parameter int WAKE_CYCLES = 1000
) (
    input  logic               Bus2IP_Clk,
    input  logic               Bus2IP_Reset,
    input  logic               ctrl_enable,
    input  logic [15:0]        clk_div,
    input  logic               fmt_twos,
    input  logic               wr_valid,
    input  logic [9:0]         wr_data,
    output logic               wr_ready,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               underflow,
    input  logic               underflow_clr,
    output logic               busy,
    output logic [9:0]         dac_data,
    output logic               dac_dclk,
    output logic               dac_pwrdn,
    output logic               dac_pinmd,
    output logic               dac_clkmd,
    output logic               dac_format
);

    localparam int DEPTH  = 2 ** FIFO_AW;
    localparam int WAKE_W = $clog2(WAKE_CYCLES) + 1;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_WAKE,
        ST_RUN,
        ST_STOP
    } state_t;

    state_t              state;
    logic [WAKE_W-1:0]   wake_cnt;
    logic [16:0]         phase;
    logic [15:0]         div_lat;
    logic                stop_pend;

    logic [9:0]          mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr;
    logic [FIFO_AW-1:0]  rd_ptr;

    logic                push;
    logic                pop;
    logic                flush;
    logic [16:0]         rise_pt;
    logic [16:0]         end_pt;

    function automatic logic [9:0] midscale(input logic twos);
        return twos ? 10'h000 : 10'h200;
    endfunction

    // Occupancy never exceeds DEPTH, so the top level bit alone flags "full".
    assign wr_ready  = ~fifo_level[FIFO_AW];
    assign push      = wr_valid & wr_ready;
    // Pop decision uses the registered level, so a word written this cycle
    // can never be popped in the same cycle.
    assign pop       = (state == ST_RUN) && (phase == 17'd0) && (fifo_level != '0);
    assign flush     = (state == ST_STOP);

    // 17-bit phase arithmetic: clk_div = 16'hFFFF gives end_pt = 131071.
    assign rise_pt   = {1'b0, div_lat} + 17'd1;
    assign end_pt    = {div_lat, 1'b1};

    assign busy      = (state != ST_OFF);
    assign dac_pinmd = 1'b1;
    assign dac_clkmd = 1'b0;

    // Sample storage carries data only; it needs no reset.
    always_ff @(posedge Bus2IP_Clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            state      <= ST_OFF;
            wake_cnt   <= '0;
            phase      <= '0;
            div_lat    <= '0;
            stop_pend  <= 1'b0;
            dac_data   <= 10'h200;
            dac_dclk   <= 1'b0;
            dac_pwrdn  <= 1'b1;
            dac_format <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            dac_format <= fmt_twos;

            // A set later in this block overrides the clear.
            if (underflow_clr) underflow <= 1'b0;

            case (state)
                ST_OFF: begin
                    dac_pwrdn <= 1'b1;
                    dac_dclk  <= 1'b0;
                    dac_data  <= midscale(fmt_twos);
                    stop_pend <= 1'b0;
                    if (ctrl_enable) begin
                        state     <= ST_WAKE;
                        wake_cnt  <= WAKE_W'(WAKE_CYCLES - 1);
                        dac_pwrdn <= 1'b0;
                    end
                end

                ST_WAKE: begin
                    if (!ctrl_enable) begin
                        state     <= ST_OFF;
                        dac_pwrdn <= 1'b1;
                    end else if (wake_cnt == '0) begin
                        state <= ST_RUN;
                        phase <= '0;
                    end else begin
                        wake_cnt <= wake_cnt - 1'b1;
                    end
                end

                ST_RUN: begin
                    // A drop of enable is remembered so the period still runs out.
                    if (!ctrl_enable) stop_pend <= 1'b1;

                    if (phase == 17'd0) begin
                        div_lat  <= clk_div;
                        dac_dclk <= 1'b0;
                        phase    <= 17'd1;
                        if (fifo_level != '0) begin
                            dac_data <= mem[rd_ptr];
                        end else begin
                            underflow <= 1'b1;
                        end
                    end else if (phase == end_pt) begin
                        phase <= '0;
                        if (stop_pend || !ctrl_enable) state <= ST_STOP;
                    end else begin
                        phase <= phase + 1'b1;
                    end

                    // With clk_div = 0 the rise point coincides with period end.
                    if ((phase != 17'd0) && (phase == rise_pt)) dac_dclk <= 1'b1;
                end

                ST_STOP: begin
                    dac_data  <= midscale(fmt_twos);
                    dac_dclk  <= 1'b0;
                    dac_pwrdn <= 1'b1;
                    stop_pend <= 1'b0;
                    state     <= ST_OFF;
                end

                default: state <= ST_OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// tb_dac_sample_sequencer
//   Directed bench for dac_sample_sequencer with WAKE_CYCLES = 8.
//   Inputs change 1 time unit after a rising edge, and outputs are sampled
//   at that same point.
module tb_dac_sample_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_enable;
    logic [15:0] clk_div;
    logic        fmt_twos;
    logic        wr_valid;
    logic [9:0]  wr_data;
    logic        wr_ready;
    logic [4:0]  fifo_level;
    logic        underflow;
    logic        underflow_clr;
    logic        busy;
    logic [9:0]  dac_data;
    logic        dac_dclk;
    logic        dac_pwrdn;
    logic        dac_pinmd;
    logic        dac_clkmd;
    logic        dac_format;

    int n_checks = 0;
    int n_errors = 0;

    dac_sample_sequencer #(
        .FIFO_AW     (4),
        .WAKE_CYCLES (8)
    ) dut (
        .Bus2IP_Clk    (clk),
        .Bus2IP_Reset  (rst),
        .ctrl_enable   (ctrl_enable),
        .clk_div       (clk_div),
        .fmt_twos      (fmt_twos),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .fifo_level    (fifo_level),
        .underflow     (underflow),
        .underflow_clr (underflow_clr),
        .busy          (busy),
        .dac_data      (dac_data),
        .dac_dclk      (dac_dclk),
        .dac_pwrdn     (dac_pwrdn),
        .dac_pinmd     (dac_pinmd),
        .dac_clkmd     (dac_clkmd),
        .dac_format    (dac_format)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [9:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick(1);
        wr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        ctrl_enable   = 1'b0;
        clk_div       = 16'd2;
        fmt_twos      = 1'b0;
        wr_valid      = 1'b0;
        wr_data       = 10'h000;
        underflow_clr = 1'b0;
        tick(2);

        // Reset state
        chk("rst_pwrdn",  dac_pwrdn,  1);
        chk("rst_level",  fifo_level, 0);
        chk("rst_ready",  wr_ready,   1);
        chk("rst_data",   dac_data,   10'h200);
        chk("rst_dclk",   dac_dclk,   0);
        chk("rst_busy",   busy,       0);
        chk("rst_uflow",  underflow,  0);
        chk("rst_fmt",    dac_format, 0);
        chk("pinmd",      dac_pinmd,  1);
        chk("clkmd",      dac_clkmd,  0);
        rst = 1'b0;

        // Preload, then wake: E0 is the edge that enters WAKE
        push(10'h3FF);
        push(10'h001);
        push(10'h155);
        chk("preload_level", fifo_level, 3);
        ctrl_enable = 1'b1;
        tick(1);                                  // E0
        chk("wake_pwrdn", dac_pwrdn, 0);
        chk("wake_busy",  busy,      1);
        tick(7);                                  // E7
        chk("wake_e7_level", fifo_level, 3);
        chk("wake_e7_data",  dac_data,   10'h200);
        tick(1);                                  // E8: first RUN cycle, pop issued
        chk("wake_e8_level", fifo_level, 3);
        chk("wake_e8_data",  dac_data,   10'h200);
        tick(1);                                  // E9: popped word visible
        chk("s1_data",  dac_data,   10'h3FF);
        chk("s1_level", fifo_level, 2);
        chk("s1_dclk",  dac_dclk,   0);
        tick(2);                                  // E11
        chk("s1_dclk_lo", dac_dclk, 0);
        tick(1);                                  // E12
        chk("s1_dclk_hi", dac_dclk, 1);
        tick(2);                                  // E14
        chk("s1_hold",  dac_data, 10'h3FF);
        tick(1);                                  // E15
        chk("s2_data",  dac_data,   10'h001);
        chk("s2_level", fifo_level, 1);
        chk("s2_dclk",  dac_dclk,   0);
        tick(3);                                  // E18
        chk("s2_dclk_hi", dac_dclk, 1);
        tick(3);                                  // E21
        chk("s3_data",  dac_data,   10'h155);
        chk("s3_level", fifo_level, 0);
        chk("s3_uflow", underflow,  0);

        // Underflow
        tick(6);                                  // E27
        chk("uf_set",  underflow, 1);
        chk("uf_hold", dac_data,  10'h155);
        underflow_clr = 1'b1;
        tick(1);                                  // E28
        chk("uf_clr", underflow, 0);
        underflow_clr = 1'b0;
        tick(4);                                  // E32
        chk("uf_clr_stay", underflow, 0);
        underflow_clr = 1'b1;
        tick(1);                                  // E33: clear and new underflow together
        chk("uf_set_wins", underflow, 1);
        underflow_clr = 1'b0;

        // Refill, then push and pop in the same cycle
        push(10'h0AA);                            // E34
        push(10'h0BB);                            // E35
        push(10'h0CC);                            // E36
        push(10'h0DD);                            // E37
        chk("refill_level", fifo_level, 4);
        tick(1);                                  // E38
        push(10'h0EE);                            // E39: push with pop
        chk("pushpop_level", fifo_level, 4);
        chk("pushpop_data",  dac_data,   10'h0AA);

        // Stop mid-period with level 4, two's-complement midscale
        fmt_twos = 1'b1;
        tick(1);                                  // E40
        chk("fmt_follow", dac_format, 1);
        ctrl_enable = 1'b0;
        tick(3);                                  // E43
        chk("stop_dclk",  dac_dclk,   1);
        chk("stop_busy",  busy,       1);
        tick(1);                                  // E44: period over, in STOP
        chk("stop_level_kept", fifo_level, 4);
        chk("stop_data_kept",  dac_data,   10'h0AA);
        chk("stop_pwrdn_lo",   dac_pwrdn,  0);
        tick(1);                                  // E45: back in OFF
        chk("off_data",  dac_data,   10'h000);
        chk("off_level", fifo_level, 0);
        chk("off_pwrdn", dac_pwrdn,  1);
        chk("off_busy",  busy,       0);
        chk("off_dclk",  dac_dclk,   0);

        // Full FIFO
        for (int i = 0; i < 16; i++) push(10'(i + 16));
        chk("full_level", fifo_level, 16);
        chk("full_ready", wr_ready,   0);
        push(10'h3AA);
        chk("full_17th", fifo_level, 16);

        // Enable dropped during WAKE returns straight to OFF
        ctrl_enable = 1'b1;
        tick(1);
        chk("abort_busy", busy, 1);
        ctrl_enable = 1'b0;
        tick(1);
        chk("abort_off",   busy,       0);
        chk("abort_pwrdn", dac_pwrdn,  1);
        chk("abort_level", fifo_level, 16);

        // Reset in the middle of RUN with level 5
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) push(10'(i + 100));
        ctrl_enable = 1'b1;
        tick(10);                                 // E9 after WAKE entry
        chk("run_level5", fifo_level, 5);
        chk("run_busy",   busy,       1);
        rst = 1'b1;
        ctrl_enable = 1'b0;
        tick(2);
        chk("mrst_pwrdn", dac_pwrdn,  1);
        chk("mrst_level", fifo_level, 0);
        chk("mrst_data",  dac_data,   10'h200);
        chk("mrst_busy",  busy,       0);
        chk("mrst_uflow", underflow,  0);
        chk("mrst_ready", wr_ready,   1);
        rst = 1'b0;
        tick(1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
